// File: rtl/frame_store_pkg.sv
// Shared types and constants for the frame store: buffer indices, buffer roles
// and the default address width.
package frame_store_pkg;

  localparam int FS_ADDR_BITS = 17;

  typedef logic [1:0] buf_idx_t;

  typedef enum logic [1:0] {
    ROLE_WRITE   = 2'd0,
    ROLE_READY   = 2'd1,
    ROLE_DISPLAY = 2'd2,
    ROLE_FREE    = 2'd3
  } role_e;

endpackage

// File: rtl/frame_store_bram.sv
// Simple dual-port RAM: one write port and one registered read port.
// The contents are never cleared.
module frame_store_bram #(
  parameter int WIDTH     = 4,
  parameter int ADDR_BITS = 17
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [WIDTH-1:0]     o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_BITS];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_store.sv
// Double/triple-buffered frame store with a fixed-priority, multi-port read path.
// Reads always target the display buffer; the buffer index is captured when the read is granted.
module frame_store
  import frame_store_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int ADDR_BITS   = FS_ADDR_BITS,
  parameter int NUM_BUFFERS = 3,
  parameter int NUM_READERS = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           write_valid_in,
  input  logic [ADDR_BITS-1:0]           write_addr_in,
  input  logic [WIDTH-1:0]               write_data_in,
  input  logic                           frame_done_in,
  output logic                           write_ready_out,
  input  logic                           frame_start_in,
  input  logic [NUM_READERS-1:0]         read_req_in,
  input  logic [NUM_READERS*ADDR_BITS-1:0] read_addr_in,
  output logic [NUM_READERS-1:0]         read_grant_out,
  output logic                           read_valid_out,
  output logic [1:0]                     read_id_out,
  output logic [WIDTH-1:0]               read_data_out,
  output logic [1:0]                     write_buffer_out,
  output logic [1:0]                     display_buffer_out,
  output logic                           ready_valid_out,
  output logic [15:0]                    dropped_frames_out
);

  localparam logic THREE = (NUM_BUFFERS == 3);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  buf_idx_t    r_write_idx;
  buf_idx_t    r_display_idx;
  buf_idx_t    r_spare_idx;
  logic        r_ready_valid;
  logic [15:0] r_dropped;
  logic        w_write_en;

  // With two buffers the READY frame sits in the write buffer, which stalls the writer.
  assign write_ready_out = THREE | ~r_ready_valid;
  assign w_write_en      = write_valid_in & write_ready_out;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_write_idx   <= 2'd0;
      r_display_idx <= 2'd1;
      r_spare_idx   <= 2'd2;
      r_ready_valid <= 1'b0;
      r_dropped     <= 16'd0;
    end else if (THREE) begin
      if (frame_done_in && frame_start_in) begin
        r_display_idx <= r_write_idx;
        r_write_idx   <= r_display_idx;
        r_ready_valid <= 1'b0;
        if (r_ready_valid) r_dropped <= sat_inc16(r_dropped);
      end else if (frame_done_in) begin
        r_write_idx   <= r_spare_idx;
        r_spare_idx   <= r_write_idx;
        r_ready_valid <= 1'b1;
        if (r_ready_valid) r_dropped <= sat_inc16(r_dropped);
      end else if (frame_start_in && r_ready_valid) begin
        r_display_idx <= r_spare_idx;
        r_spare_idx   <= r_display_idx;
        r_ready_valid <= 1'b0;
      end
    end else begin
      if (frame_done_in && r_ready_valid) r_dropped <= sat_inc16(r_dropped);
      if (frame_start_in && (frame_done_in || r_ready_valid)) begin
        r_display_idx <= r_write_idx;
        r_write_idx   <= r_display_idx;
        r_ready_valid <= 1'b0;
      end else if (frame_done_in) begin
        r_ready_valid <= 1'b1;
      end
    end
  end

  assign write_buffer_out   = r_write_idx;
  assign display_buffer_out = r_display_idx;
  assign ready_valid_out    = r_ready_valid;
  assign dropped_frames_out = r_dropped;

  logic [NUM_READERS-1:0] w_grant;
  logic [1:0]             w_grant_id;
  logic                   w_grant_any;
  logic [ADDR_BITS-1:0]   w_read_addr;

  always_comb begin
    w_grant     = '0;
    w_grant_id  = '0;
    w_grant_any = 1'b0;
    w_read_addr = '0;
    for (int i = NUM_READERS - 1; i >= 0; i--) begin
      if (read_req_in[i]) begin
        w_grant     = '0;
        w_grant[i]  = 1'b1;
        w_grant_id  = 2'(i);
        w_grant_any = 1'b1;
        w_read_addr = read_addr_in[i*ADDR_BITS +: ADDR_BITS];
      end
    end
  end

  assign read_grant_out = w_grant;

  logic [WIDTH-1:0] w_rd_data [4];

  for (genvar b = 0; b < 4; b++) begin : g_buf
    if (b < NUM_BUFFERS) begin : g_ram
      frame_store_bram #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) u_bram (
        .i_clk   (clk_in),
        .i_we    (w_write_en && (r_write_idx == 2'(b))),
        .i_waddr (write_addr_in),
        .i_wdata (write_data_in),
        .i_raddr (w_read_addr),
        .o_rdata (w_rd_data[b])
      );
    end else begin : g_none
      assign w_rd_data[b] = '0;
    end
  end

  buf_idx_t         r_buf_p1;
  logic [1:0]       r_id_p1;
  logic             r_vld_p1;
  logic [1:0]       r_id_p2;
  logic [WIDTH-1:0] r_data_p2;
  logic             r_vld_p2;

  // p1: RAM read in flight, buffer index frozen at grant
  always_ff @(posedge clk_in) begin
    r_buf_p1 <= r_display_idx;
    r_id_p1  <= w_grant_id;
  end

  // p2: select the captured buffer and present the result
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_id_p2   <= 2'd0;
      r_data_p2 <= '0;
    end else begin
      r_vld_p1 <= w_grant_any;
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_id_p2   <= r_id_p1;
        r_data_p2 <= w_rd_data[r_buf_p1];
      end
    end
  end

  assign read_valid_out = r_vld_p2;
  assign read_id_out    = r_id_p2;
  assign read_data_out  = r_data_p2;

endmodule

// File: tb/tb_frame_store.sv
// Bench for frame_store: a 3-buffer and a 2-buffer instance share the same stimulus and
// are compared against a role-based reference model.
module tb_frame_store;

  localparam int AB = 17;
  localparam int W  = 4;
  localparam int NR = 2;
  localparam int RW = 0, RR = 1, RD = 2, RF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, wv, done, start;
  logic [AB-1:0]    waddr;
  logic [W-1:0]     wdata;
  logic [NR-1:0]    req;
  logic [NR*AB-1:0] raddr;

  logic          wrdy  [2];
  logic [NR-1:0] gnt   [2];
  logic          rvld  [2];
  logic [1:0]    rid   [2];
  logic [W-1:0]  rdata [2];
  logic [1:0]    wbuf  [2];
  logic [1:0]    dbuf  [2];
  logic          rv    [2];
  logic [15:0]   drop  [2];

  frame_store #(.WIDTH(W), .ADDR_BITS(AB), .NUM_BUFFERS(3), .NUM_READERS(NR)) dut3 (
    .clk_in(clk), .rst_in(rst), .write_valid_in(wv), .write_addr_in(waddr),
    .write_data_in(wdata), .frame_done_in(done), .write_ready_out(wrdy[0]),
    .frame_start_in(start), .read_req_in(req), .read_addr_in(raddr),
    .read_grant_out(gnt[0]), .read_valid_out(rvld[0]), .read_id_out(rid[0]),
    .read_data_out(rdata[0]), .write_buffer_out(wbuf[0]), .display_buffer_out(dbuf[0]),
    .ready_valid_out(rv[0]), .dropped_frames_out(drop[0]));

  frame_store #(.WIDTH(W), .ADDR_BITS(AB), .NUM_BUFFERS(2), .NUM_READERS(NR)) dut2 (
    .clk_in(clk), .rst_in(rst), .write_valid_in(wv), .write_addr_in(waddr),
    .write_data_in(wdata), .frame_done_in(done), .write_ready_out(wrdy[1]),
    .frame_start_in(start), .read_req_in(req), .read_addr_in(raddr),
    .read_grant_out(gnt[1]), .read_valid_out(rvld[1]), .read_id_out(rid[1]),
    .read_data_out(rdata[1]), .write_buffer_out(wbuf[1]), .display_buffer_out(dbuf[1]),
    .ready_valid_out(rv[1]), .dropped_frames_out(drop[1]));

  // Reference model: index 0 models the 3-buffer instance, index 1 the 2-buffer one.
  typedef struct { int due; int id; int data; } rd_t;
  int  role  [2][3];
  int  mdrop [2];
  int  mem   [2][3][16];
  rd_t rq    [2][$];
  int  cyc;
  int  checks;
  int  errors;

  function automatic int nbuf(int k); return (k == 0) ? 3 : 2; endfunction

  function automatic int find_role(int k, int r);
    for (int b = 0; b < nbuf(k); b++) if (role[k][b] == r) return b;
    return -1;
  endfunction

  function automatic int exp_wbuf(int k);
    int b = find_role(k, RW);
    return (b >= 0) ? b : find_role(k, RR);
  endfunction

  function automatic int exp_dbuf(int k); return find_role(k, RD); endfunction
  function automatic bit exp_rv(int k);   return find_role(k, RR) >= 0; endfunction
  function automatic bit exp_wrdy(int k); return find_role(k, RW) >= 0; endfunction

  function automatic int low_id(logic [NR-1:0] r);
    for (int i = 0; i < NR; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic int low_mask(logic [NR-1:0] r);
    int i = low_id(r);
    return (i < 0) ? 0 : (1 << i);
  endfunction

  task automatic bump(int k);
    if (mdrop[k] < 65535) mdrop[k]++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      role[k][0] = RW; role[k][1] = RD; role[k][2] = RF;
      mdrop[k] = 0;
      rq[k].delete();
    end
  endtask

  task automatic model_edge();
    int w, d, r, f, id, a;
    rd_t e;
    if (rst) begin model_reset(); return; end
    for (int k = 0; k < 2; k++) begin
      id = low_id(req);
      if (id >= 0) begin
        a = int'(raddr[id*AB +: AB]);
        e.due = cyc + 2; e.id = id;
        e.data = (a < 16) ? mem[k][exp_dbuf(k)][a] : -1;
        rq[k].push_back(e);
      end
      w = find_role(k, RW); d = find_role(k, RD); r = find_role(k, RR); f = find_role(k, RF);
      if (wv && w >= 0 && int'(waddr) < 16) mem[k][w][int'(waddr)] = int'(wdata);
      if (k == 0) begin
        if (done && start) begin
          role[k][w] = RD; role[k][d] = RW;
          if (r >= 0) begin role[k][r] = RF; bump(k); end
        end else if (done) begin
          role[k][w] = RR;
          if (r >= 0) begin role[k][r] = RW; bump(k); end
          else role[k][f] = RW;
        end else if (start && r >= 0) begin
          role[k][r] = RD; role[k][d] = RF;
        end
      end else begin
        if (done && w < 0) bump(k);
        if (start && (done || r >= 0)) begin
          if (w >= 0) role[k][w] = RD; else role[k][r] = RD;
          role[k][d] = RW;
        end else if (done && w >= 0) begin
          role[k][w] = RR;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    for (int k = 0; k < 2; k++)
      while (rq[k].size() > 0 && rq[k][0].due < cyc) rq[k].delete(0);
    #1;
  endtask

  task automatic idle_inputs();
    wv = 0; done = 0; start = 0; req = '0; waddr = '0; wdata = '0; raddr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (wbuf[k] !== 2'd0) begin errors++; $display("FAIL reset_wbuf dut%0d got %0d want 0", k, wbuf[k]); end
      checks++; if (dbuf[k] !== 2'd1) begin errors++; $display("FAIL reset_dbuf dut%0d got %0d want 1", k, dbuf[k]); end
      checks++; if (rv[k] !== 1'b0) begin errors++; $display("FAIL reset_rv dut%0d got %0b want 0", k, rv[k]); end
      checks++; if (wrdy[k] !== 1'b1) begin errors++; $display("FAIL reset_wrdy dut%0d got %0b want 1", k, wrdy[k]); end
      checks++; if (rvld[k] !== 1'b0 || rid[k] !== 2'd0 || rdata[k] !== 4'd0)
        begin errors++; $display("FAIL reset_read dut%0d got vld=%0b id=%0d data=%0h want 0/0/0", k, rvld[k], rid[k], rdata[k]); end
      checks++; if (drop[k] !== 16'd0) begin errors++; $display("FAIL reset_drop dut%0d got %0d want 0", k, drop[k]); end
    end
  endtask

  task automatic test_basic_read();
    do_reset();
    wv = 1; waddr = 5; wdata = 4'hA; tick(); wv = 0;
    done = 1; tick(); done = 0;
    @(negedge clk);
    checks++; if (rv[0] !== 1'b1) begin errors++; $display("FAIL basic_rv dut0 got %0b want 1", rv[0]); end
    start = 1; tick(); start = 0;
    req = 2'b01; raddr = '0; raddr[AB-1:0] = 5;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (gnt[k] !== 2'b01) begin errors++; $display("FAIL basic_grant dut%0d got %b want 01", k, gnt[k]); end
    end
    tick(); req = '0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (rvld[k] !== 1'b0) begin errors++; $display("FAIL basic_early dut%0d got vld=%0b want 0", k, rvld[k]); end
    end
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (rvld[k] !== 1'b1 || rid[k] !== 2'd0 || rdata[k] !== 4'hA)
        begin errors++; $display("FAIL basic_read dut%0d got vld=%0b id=%0d data=%0h want 1/0/a", k, rvld[k], rid[k], rdata[k]); end
    end
  endtask

  task automatic test_drop3();
    do_reset();
    done = 1; tick(); done = 0; tick();
    done = 1; tick(); done = 0;
    @(negedge clk);
    checks++; if (drop[0] !== 16'd1 || wrdy[0] !== 1'b1 || rv[0] !== 1'b1)
      begin errors++; $display("FAIL drop3 dut0 got drop=%0d wrdy=%0b rv=%0b want 1/1/1", drop[0], wrdy[0], rv[0]); end
    checks++; if (drop[1] !== 16'd1 || wrdy[1] !== 1'b0 || rv[1] !== 1'b1)
      begin errors++; $display("FAIL drop_stalled dut1 got drop=%0d wrdy=%0b rv=%0b want 1/0/1", drop[1], wrdy[1], rv[1]); end
  endtask

  task automatic test_stall2();
    do_reset();
    wv = 1; waddr = 7; wdata = 4'h3; tick(); wv = 0;
    done = 1; tick(); done = 0;
    @(negedge clk);
    checks++; if (wrdy[1] !== 1'b0) begin errors++; $display("FAIL stall_wrdy dut1 got %0b want 0", wrdy[1]); end
    wv = 1; waddr = 7; wdata = 4'h9; tick(); wv = 0;
    start = 1; tick(); start = 0;
    @(negedge clk);
    checks++; if (wrdy[1] !== 1'b1 || wbuf[1] !== 2'd1 || dbuf[1] !== 2'd0)
      begin errors++; $display("FAIL stall_swap dut1 got wrdy=%0b wbuf=%0d dbuf=%0d want 1/1/0", wrdy[1], wbuf[1], dbuf[1]); end
    req = 2'b01; raddr = '0; raddr[AB-1:0] = 7; tick(); req = '0; tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (rvld[k] !== 1'b1 || rdata[k] !== 4'h3)
        begin errors++; $display("FAIL stall_discard dut%0d got vld=%0b data=%0h want 1/3", k, rvld[k], rdata[k]); end
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    req = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++; if (gnt[k] !== 2'b01) begin errors++; $display("FAIL prio_both dut%0d cycle %0d got %b want 01", k, c, gnt[k]); end
      end
      tick();
    end
    req = 2'b10;
    @(negedge clk);
    checks++; if (gnt[0] !== 2'b10) begin errors++; $display("FAIL prio_port1 got %b want 10", gnt[0]); end
    tick(); req = '0;
    @(negedge clk);
    checks++; if (gnt[1] !== 2'b00) begin errors++; $display("FAIL prio_none got %b want 00", gnt[1]); end
    tick();
    @(negedge clk);
    checks++; if (rvld[0] !== 1'b1 || rid[0] !== 2'd1)
      begin errors++; $display("FAIL prio_id got vld=%0b id=%0d want 1/1", rvld[0], rid[0]); end
  endtask

  task automatic test_simul();
    do_reset();
    done = 1; tick(); done = 0;
    done = 1; start = 1; tick(); done = 0; start = 0;
    @(negedge clk);
    checks++; if (dbuf[0] !== 2'd2 || wbuf[0] !== 2'd1 || rv[0] !== 1'b0 || drop[0] !== 16'd1)
      begin errors++; $display("FAIL simul dut0 got dbuf=%0d wbuf=%0d rv=%0b drop=%0d want 2/1/0/1", dbuf[0], wbuf[0], rv[0], drop[0]); end
    checks++; if (dbuf[1] !== 2'd0 || wbuf[1] !== 2'd1 || rv[1] !== 1'b0 || drop[1] !== 16'd1)
      begin errors++; $display("FAIL simul dut1 got dbuf=%0d wbuf=%0d rv=%0b drop=%0d want 0/1/0/1", dbuf[1], wbuf[1], rv[1], drop[1]); end
  endtask

  task automatic test_swap_inflight();
    do_reset();
    wv = 1; waddr = 3; wdata = 4'h5; tick(); wv = 0;
    done = 1; tick(); done = 0;
    start = 1; tick(); start = 0;
    wv = 1; waddr = 3; wdata = 4'hC; tick(); wv = 0;
    done = 1; tick(); done = 0;
    req = 2'b01; raddr = '0; raddr[AB-1:0] = 3; tick(); req = '0;
    start = 1; tick(); start = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (rvld[k] !== 1'b1 || rdata[k] !== 4'h5)
        begin errors++; $display("FAIL inflight_old dut%0d got vld=%0b data=%0h want 1/5", k, rvld[k], rdata[k]); end
    end
    req = 2'b01; tick(); req = '0; tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (rvld[k] !== 1'b1 || rdata[k] !== 4'hC)
        begin errors++; $display("FAIL inflight_new dut%0d got vld=%0b data=%0h want 1/c", k, rvld[k], rdata[k]); end
    end
    req = 2'b01; tick(); req = '0; rst = 1; tick(); rst = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (rvld[k] !== 1'b0) begin errors++; $display("FAIL reset_midread dut%0d got vld=%0b want 0", k, rvld[k]); end
    end
    tick();
    @(negedge clk);
    checks++; if (rvld[0] !== 1'b0) begin errors++; $display("FAIL reset_midread_late got vld=%0b want 0", rvld[0]); end
  endtask

  task automatic test_random();
    bit expv;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      wv    = !rst && ($urandom_range(0, 1) == 1);
      waddr = AB'($urandom_range(0, 15));
      wdata = W'($urandom);
      done  = ($urandom_range(0, 11) == 0);
      start = ($urandom_range(0, 9) == 0);
      req   = ($urandom_range(0, 4) < 2) ? NR'($urandom) : '0;
      raddr = '0;
      for (int p = 0; p < NR; p++) raddr[p*AB +: AB] = AB'($urandom_range(0, 15));
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++; if (wbuf[k] !== 2'(exp_wbuf(k)) || dbuf[k] !== 2'(exp_dbuf(k)))
          begin errors++; $display("FAIL rand_idx dut%0d cyc %0d got w=%0d d=%0d want w=%0d d=%0d", k, cyc, wbuf[k], dbuf[k], exp_wbuf(k), exp_dbuf(k)); end
        checks++; if (rv[k] !== exp_rv(k) || wrdy[k] !== exp_wrdy(k))
          begin errors++; $display("FAIL rand_flags dut%0d cyc %0d got rv=%0b wrdy=%0b want %0b/%0b", k, cyc, rv[k], wrdy[k], exp_rv(k), exp_wrdy(k)); end
        checks++; if (drop[k] !== 16'(mdrop[k]))
          begin errors++; $display("FAIL rand_drop dut%0d cyc %0d got %0d want %0d", k, cyc, drop[k], mdrop[k]); end
        checks++; if (gnt[k] !== NR'(low_mask(req)))
          begin errors++; $display("FAIL rand_grant dut%0d cyc %0d got %b want %0d", k, cyc, gnt[k], low_mask(req)); end
        expv = (rq[k].size() > 0 && rq[k][0].due == cyc);
        checks++; if (rvld[k] !== expv)
          begin errors++; $display("FAIL rand_valid dut%0d cyc %0d got %0b want %0b", k, cyc, rvld[k], expv); end
        if (expv) begin
          checks++; if (rid[k] !== 2'(rq[k][0].id))
            begin errors++; $display("FAIL rand_id dut%0d cyc %0d got %0d want %0d", k, cyc, rid[k], rq[k][0].id); end
          if (rq[k][0].data >= 0) begin
            checks++; if (rdata[k] !== W'(rq[k][0].data))
              begin errors++; $display("FAIL rand_data dut%0d cyc %0d got %0h want %0h", k, cyc, rdata[k], rq[k][0].data); end
          end
          rq[k].delete(0);
        end
      end
      tick();
    end
    rst = 0;
  endtask

  task automatic test_saturate();
    do_reset();
    done = 1;
    for (int c = 0; c < 65540; c++) tick();
    done = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (drop[k] !== 16'hFFFF) begin errors++; $display("FAIL saturate dut%0d got %0h want ffff", k, drop[k]); end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 3; b++)
        for (int a = 0; a < 16; a++) mem[k][b][a] = -1;
    model_reset();
    rst = 1;
    idle_inputs();
    test_reset();
    test_basic_read();
    test_drop3();
    test_stall2();
    test_priority();
    test_simul();
    test_swap_inflight();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_store.md
FRAME_STORE -- requirements
Module: frame_store

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WIDTH, 4, pixel bits.
- ADDR_BITS, 17, address bits; depth is 2**ADDR_BITS per buffer.
- NUM_BUFFERS, 3, buffer count; legal values 2 or 3.
- NUM_READERS, 2, read ports; legal 1..4; port 0 is highest priority.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_in, in, 1, sole clock.
- rst_in, in, 1, synchronous active-high reset.
- write_valid_in, in, 1, pixel write strobe.
- write_addr_in, in, ADDR_BITS, write address.
- write_data_in, in, WIDTH, write pixel.
- frame_done_in, in, 1, writer finished frame (pulse).
- write_ready_out, out, 1, write buffer available.
- frame_start_in, in, 1, display vsync (pulse).
- read_req_in, in, NUM_READERS, per-port read request.
- read_addr_in, in, NUM_READERS*ADDR_BITS, packed addresses; port i at [i*ADDR_BITS +: ADDR_BITS].
- read_grant_out, out, NUM_READERS, one-hot grant, same cycle.
- read_valid_out, out, 1, read data valid.
- read_id_out, out, 2, port that issued the returned read.
- read_data_out, out, WIDTH, read pixel.
- write_buffer_out, out, 2, current write-buffer index.
- display_buffer_out, out, 2, current display-buffer index.
- ready_valid_out, out, 1, completed frame waiting for display.
- dropped_frames_out, out, 16, saturating count of dropped frames.

Function
REQ-003 Each buffer SHALL hold exactly one role: WRITE, READY, DISPLAY or FREE; exactly one buffer is WRITE and one is DISPLAY at all times.
REQ-004 A write SHALL commit when write_valid_in=1 and write_ready_out=1; writes with write_ready_out=0 SHALL be discarded.
REQ-005 A write in the same cycle as frame_done_in SHALL land in the pre-swap write buffer.
REQ-006 frame_done_in alone, NUM_BUFFERS=3: the WRITE buffer becomes READY and ready_valid_out rises. The new WRITE buffer is the previous READY buffer if one was valid, otherwise the FREE buffer. If a READY frame was overwritten, dropped_frames_out increments.
REQ-007 frame_done_in alone, NUM_BUFFERS=2: the WRITE buffer becomes READY, ready_valid_out rises, and write_ready_out falls the next cycle. frame_done_in while already stalled SHALL be ignored and SHALL increment dropped_frames_out.
REQ-008 frame_start_in alone with ready_valid_out=1: READY becomes DISPLAY and ready_valid_out clears. The old DISPLAY buffer becomes FREE (3 buffers) or WRITE (2 buffers, write_ready_out rises). With ready_valid_out=0, frame_start_in has no effect.
REQ-009 frame_done_in and frame_start_in in the same cycle: the completed WRITE buffer becomes DISPLAY directly and the old DISPLAY becomes WRITE. Any prior READY frame is dropped (becomes FREE, counter increments) and ready_valid_out=0.
REQ-010 Role changes SHALL take effect on the clock edge after the event; index outputs are registered.
REQ-011 Arbitration SHALL be fixed priority: the lowest-numbered requesting port is granted, one grant per cycle, and read_grant_out is combinational from read_req_in.
REQ-012 Read latency SHALL be exactly 2 cycles from grant to read_valid_out=1, with read_id_out equal to the granted port.
REQ-013 The buffer index SHALL be captured at grant; in-flight reads complete from that buffer even if a swap intervenes.
REQ-014 Reads of the current WRITE buffer are impossible by construction; reads always target DISPLAY.
REQ-015 dropped_frames_out SHALL saturate at 16'hFFFF.

Reset
REQ-016 On rst_in, all roles, indices and counters SHALL return to reset values at the next edge, regardless of in-flight events, and any pending read SHALL be discarded.
REQ-017 Reset values:
- write_buffer_out=0, display_buffer_out=1; buffer 2 FREE when NUM_BUFFERS=3.
- ready_valid_out=0, write_ready_out=1, read_valid_out=0, read_id_out=0, read_data_out=0.
- dropped_frames_out=0.
REQ-018 Memory contents SHALL NOT be reset.

Structure
REQ-019 The buffer-index typedef and the role enum (WRITE/READY/DISPLAY/FREE) SHALL live in the shared types header; ADDR_BITS defaults SHALL come from the existing shared constant.
REQ-020 One sub-module, frame_store_bram, SHALL be used: a simple dual-port RAM (one write port, one registered read port) instantiated NUM_BUFFERS times.

Verification
REQ-021 Write addr 5 data 4'hA, frame_done_in, frame_start_in; port 0 reads addr 5 -> read_valid_out 2 cycles after grant, data 4'hA, id 0.
REQ-022 3 buffers, two frame_done_in pulses with no frame_start_in -> dropped_frames_out=1, write_ready_out stays 1, ready_valid_out=1.
REQ-023 2 buffers, frame_done_in -> write_ready_out=0 and subsequent write discarded; frame_start_in -> write_ready_out=1 and the buffer indices swapped.
REQ-024 Ports 0 and 1 request simultaneously for 3 cycles -> grant always port 0; port 1 granted the cycle after port 0 deasserts.
REQ-025 Simultaneous frame_done_in and frame_start_in with a READY frame pending -> display equals the old write index, ready_valid_out=0, dropped_frames_out+1.
REQ-026 Grant a read, then frame_start_in next cycle -> returned data comes from the old display buffer; rst_in mid-read -> no read_valid_out.
